mem_access_unit: RTL and testbench

// - Parametrised successor of the datapath's MAR/MDR/RAM path: owns MAR and MDR and drives an external

---
 rtl/cpu_pkg.sv | 19 +
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU datapath memory access path.
package cpu_pkg;

    localparam int unsigned CPU_DATA_W  = 32;
    localparam int unsigned CPU_ADDR_W  = 9;
    localparam int unsigned MAU_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mau_state_t;

    // Counter width able to hold 0..limit-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-state counter, cleared on access start; flags the last
// permitted cycle of an access.
module mem_wait_timer
    import cpu_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned     CW   = cnt_width(LIMIT);
    localparam logic [CW-1:0]   LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR owner driving an external memory over a req/ack handshake with
// variable wait states and an optional access timeout.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = CPU_DATA_W,
    parameter int unsigned ADDR_W  = CPU_ADDR_W,
    parameter int unsigned TIMEOUT = MAU_TIMEOUT
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              rd_start,
    input  logic              wr_start,
    output logic [DATA_W-1:0] mdr_out,
    output logic [ADDR_W-1:0] mar_out,
    output logic              busy,
    output logic              mem_done,
    output logic              mem_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    mau_state_t        state_q;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              busy_q, done_q, err_q, req_q, we_q;

    logic in_idle, in_access, start_ok, start_bad, read_ack, timed_out;

    assign in_idle   = (state_q == IDLE);
    assign in_access = (state_q == ACCESS);
    assign start_ok  = rd_start ^ wr_start;
    assign start_bad = rd_start & wr_start;
    assign read_ack  = in_access && mem_ack && !we_q;

    // Loads are only honoured in IDLE so address/data stay frozen during a request.
    always_comb begin
        mar_d = mar_q;
        if (in_idle && MARin) begin
            mar_d = bus_in[ADDR_W-1:0];
        end
    end

    always_comb begin
        mdr_d = mdr_q;
        if (read_ack) begin
            mdr_d = mem_rdata;
        end else if (in_idle && MDRin) begin
            mdr_d = bus_in;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timer
            mem_wait_timer #(
                .LIMIT (TIMEOUT)
            ) u_timer (
                .clk_i     (clock),
                .rst_i     (clear),
                .start_i   (in_idle && start_ok),
                .en_i      (in_access),
                .expired_o (timed_out)
            );
        end else begin : g_no_timer
            assign timed_out = 1'b0;
        end
    endgenerate

    // An ack on the last permitted cycle still completes normally.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (start_bad) begin
                        state_q <= DONE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (start_ok) begin
                        state_q <= ACCESS;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        we_q    <= wr_start;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (timed_out) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mdr_out   = mdr_q;
    assign mar_out   = mar_q;
    assign busy      = busy_q;
    assign mem_done  = done_q;
    assign mem_err   = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of complete accesses plus
// hand-written sequences for guards, illegal start, and mid-access clear.
module tb_mem_access_unit;

    logic        clock;
    logic        clear;
    logic [31:0] bus_in;
    logic        MARin, MDRin, rd_start, wr_start;
    logic [31:0] mdr_out;
    logic [8:0]  mar_out;
    logic        busy, mem_done, mem_err, mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(
        .DATA_W  (32),
        .ADDR_W  (9),
        .TIMEOUT (16)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .bus_in    (bus_in),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .rd_start  (rd_start),
        .wr_start  (wr_start),
        .mdr_out   (mdr_out),
        .mar_out   (mar_out),
        .busy      (busy),
        .mem_done  (mem_done),
        .mem_err   (mem_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] mar_bus;
        logic [31:0] mdr_bus;
        logic        we;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_mdr;
        logic        exp_err;
        int          exp_done;
        int          exp_req;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one access; acks after 'waits' request cycles (never, if waits is
    // larger than the request lasts). Cycle 1 is the first cycle after start.
    task automatic do_access(input logic we, input int waits, input logic [31:0] rdata,
                             output int done_cyc, output int req_cyc, output logic err,
                             output logic [31:0] addr_seen, output logic stable);
        logic [31:0] a0;
        logic [31:0] w0;
        done_cyc = -1;
        req_cyc  = 0;
        err      = 1'b0;
        stable   = 1'b1;
        rd_start = !we;
        wr_start = we;
        step();
        rd_start = 1'b0;
        wr_start = 1'b0;
        a0 = 32'(mem_addr);
        w0 = mem_wdata;
        addr_seen = a0;
        for (int c = 1; c < 64; c++) begin
            if (mem_done) begin
                done_cyc = c;
                err = mem_err;
                break;
            end
            if (mem_req) begin
                req_cyc++;
                if (32'(mem_addr) != a0 || mem_wdata != w0 || mem_we != we) stable = 1'b0;
                if (req_cyc - 1 == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
            step();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end
    endtask

    initial begin
        int          done_cyc, req_cyc, n;
        logic        err, stable;
        logic [31:0] addr_seen;

        vecs[0] = '{32'h0000_0010, 32'h0,          1'b0, 0,  32'hDEADBEEF, 32'h010, 32'hDEADBEEF, 1'b0, 2,  1};
        vecs[1] = '{32'hFFFF_F1FF, 32'h1234_5678, 1'b1, 3,  32'h0,        32'h1FF, 32'h1234_5678, 1'b0, 5,  4};
        vecs[2] = '{32'h0000_00A5, 32'h0,          1'b0, 1,  32'hCAFEF00D, 32'h0A5, 32'hCAFEF00D, 1'b0, 3,  2};
        vecs[3] = '{32'h0000_0033, 32'h0,          1'b0, 99, 32'h1111_1111, 32'h033, 32'hCAFEF00D, 1'b1, 17, 16};
        vecs[4] = '{32'h0000_00C3, 32'h0,          1'b0, 15, 32'h0BADC0DE, 32'h0C3, 32'h0BADC0DE, 1'b0, 17, 16};
        vecs[5] = '{32'h0000_0100, 32'hA5A5_A5A5, 1'b1, 0,  32'h0,        32'h100, 32'hA5A5_A5A5, 1'b0, 2,  1};

        clear = 1'b1; bus_in = '0; MARin = 1'b0; MDRin = 1'b0;
        rd_start = 1'b0; wr_start = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        step();
        step();
        clear = 1'b0;
        check("reset mar_out",  32'(mar_out), 32'h0);
        check("reset mdr_out",  mdr_out,      32'h0);
        check("reset busy",     32'(busy),    32'h0);
        check("reset mem_done", 32'(mem_done), 32'h0);
        check("reset mem_err",  32'(mem_err), 32'h0);
        check("reset mem_req",  32'(mem_req), 32'h0);
        check("reset mem_we",   32'(mem_we),  32'h0);

        for (int i = 0; i < 6; i++) begin
            MARin = 1'b1; bus_in = vecs[i].mar_bus;
            step();
            MARin = 1'b0;
            if (vecs[i].we) begin
                MDRin = 1'b1; bus_in = vecs[i].mdr_bus;
                step();
                MDRin = 1'b0;
            end
            bus_in = 32'h0;
            do_access(vecs[i].we, vecs[i].waits, vecs[i].rdata, done_cyc, req_cyc, err, addr_seen, stable);
            check($sformatf("v%0d done_cycle", i), 32'(done_cyc), 32'(vecs[i].exp_done));
            check($sformatf("v%0d req_cycles", i), 32'(req_cyc),  32'(vecs[i].exp_req));
            check($sformatf("v%0d mem_err", i),    32'(err),      32'(vecs[i].exp_err));
            check($sformatf("v%0d mem_addr", i),   addr_seen,     vecs[i].exp_addr);
            check($sformatf("v%0d req_stable", i), 32'(stable),   32'h1);
            check($sformatf("v%0d mdr_out", i),    mdr_out,       vecs[i].exp_mdr);
            step();
            check($sformatf("v%0d idle_busy", i),  32'(busy),     32'h0);
        end

        // Loads and starts while busy must be ignored.
        MARin = 1'b1; bus_in = 32'h020;
        step();
        MARin = 1'b0;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        MARin = 1'b1; bus_in = 32'h0AA;
        step();
        MARin = 1'b0; MDRin = 1'b1; bus_in = 32'h55; rd_start = 1'b1;
        step();
        MDRin = 1'b0; rd_start = 1'b0; bus_in = 32'h0;
        check("guard mar_out",  32'(mar_out),  32'h020);
        check("guard mem_addr", 32'(mem_addr), 32'h020);
        check("guard mdr_out",  mdr_out,       32'hA5A5_A5A5);
        check("guard mem_req",  32'(mem_req),  32'h1);
        mem_ack = 1'b1; mem_rdata = 32'h600D_F00D;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (mem_done) n++;
            step();
        end
        check("guard done_pulses", 32'(n),        32'h1);
        check("guard read mdr",    mdr_out,       32'h600D_F00D);
        check("guard final mar",   32'(mar_out),  32'h020);

        // Both starts together: immediate error completion, no request.
        rd_start = 1'b1; wr_start = 1'b1;
        step();
        rd_start = 1'b0; wr_start = 1'b0;
        check("both mem_req",  32'(mem_req),  32'h0);
        check("both mem_done", 32'(mem_done), 32'h1);
        check("both mem_err",  32'(mem_err),  32'h1);
        check("both busy",     32'(busy),     32'h1);
        check("both mar_out",  32'(mar_out),  32'h020);
        check("both mdr_out",  mdr_out,       32'h600D_F00D);
        step();
        check("both done_low", 32'(mem_done), 32'h0);
        check("both busy_low", 32'(busy),     32'h0);

        // Load and start in the same cycle: access uses the new MAR.
        MARin = 1'b1; bus_in = 32'h077; rd_start = 1'b1;
        step();
        MARin = 1'b0; rd_start = 1'b0; bus_in = 32'h0;
        check("loadstart mem_req",  32'(mem_req),  32'h1);
        check("loadstart mem_addr", 32'(mem_addr), 32'h077);
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("loadstart mem_done", 32'(mem_done), 32'h1);
        check("loadstart mdr_out",  mdr_out,       32'h1122_3344);
        step();

        // Ack while idle is ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("idleack mdr_out",  mdr_out,       32'h1122_3344);
        check("idleack mem_done", 32'(mem_done), 32'h0);
        step();

        // Clear two cycles into a pending read.
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr mem_req",  32'(mem_req),  32'h0);
        check("clr busy",     32'(busy),     32'h0);
        check("clr mem_done", 32'(mem_done), 32'h0);
        check("clr mem_err",  32'(mem_err),  32'h0);
        check("clr mem_we",   32'(mem_we),   32'h0);
        check("clr mar_out",  32'(mar_out),  32'h0);
        check("clr mdr_out",  mdr_out,       32'h0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (mem_done || mem_req) n++;
            step();
        end
        check("clr no_activity", 32'(n), 32'h0);
        do_access(1'b0, 2, 32'h5A5A_A5A5, done_cyc, req_cyc, err, addr_seen, stable);
        check("clr2 done_cycle", 32'(done_cyc), 32'd4);
        check("clr2 req_cycles", 32'(req_cyc),  32'd3);
        check("clr2 mem_err",    32'(err),      32'h0);
        check("clr2 mem_addr",   addr_seen,     32'h0);
        check("clr2 mdr_out",    mdr_out,       32'h5A5A_A5A5);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
